fw_source_tracker: RTL and testbench
====================================

FW_SOURCE_TRACKER -- requirements
Module: fw_source_tracker

Interface
REQ-001 clk  input  1  single system clock; all state updates on rising edge.
REQ-002 reset_n  input  1  asynchronous, active-low reset.
REQ-003 id_valid  input  1  ID stage holds a valid instruction.
REQ-004 id_rs  input  5  ID source register 1.
REQ-005 id_rt  input  5  ID source register 2.
REQ-006 id_uses_rt  input  1  ID instruction reads id_rt.
REQ-007 id_dest  input  5  ID destination register (rd or rt, pre-selected by decoder).
REQ-008 id_regwrite  input  1  ID instruction writes the register file.
REQ-009 id_is_load  input  1  ID instruction is a load (opcode 6'b100011).
REQ-010 ex_flush  input  1  taken branch; instruction entering EX is squashed.
REQ-011 mem_ready  input  1  data memory ready; 0 freezes EX/MEM/WB tracking.
REQ-012 MEM_RD  output  5  destination register of instruction in MEM.
REQ-013 MEM_FW  output  1  MEM-stage result forwardable.
REQ-014 WB_RD  output  5  destination register of instruction in WB.
REQ-015 WB_FW  output  1  WB-stage result forwardable.
REQ-016 stall_id  output  1  hold PC and IF/ID register this cycle.
REQ-017 stall_cnt  output  16  saturating count of load-use stall cycles.

Function
REQ-018 Module SHALL hold three slots EX, MEM, WB, each {valid, dest[4:0], regwrite, is_load}.
REQ-019 Advance (mem_ready=1): WB<=MEM, MEM<=EX, EX<=ID fields with valid=id_valid, in one clock edge.
REQ-020 Latency: instruction accepted at edge n occupies EX after n, drives MEM_RD after n+1, WB_RD after n+2.
REQ-021 Freeze (mem_ready=0): all slots hold; stall_id=1; ex_flush ignored (branch logic holds it until advance).
REQ-022 Load-use hazard = EX.valid & EX.is_load & EX.regwrite & EX.dest!=0 & id_valid & (EX.dest==id_rs | (id_uses_rt & EX.dest==id_rt)); combinational.
REQ-023 On hazard with mem_ready=1: stall_id=1; EX receives bubble (valid=0); MEM<=EX, WB<=MEM still advance.
REQ-024 On ex_flush=1 with mem_ready=1: EX receives bubble regardless of ID fields; flush has priority over load-use; stall_id=0 unless frozen.
REQ-025 stall_id = hazard | ~mem_ready; hazard with flush still asserts stall_id.
REQ-026 MEM_RD = MEM.dest, WB_RD = WB.dest, driven directly from slot registers (no combinational path from inputs).
REQ-027 MEM_FW = MEM.valid & MEM.regwrite & ~MEM.is_load & MEM.dest!=0 (load data unavailable until WB).
REQ-028 WB_FW = WB.valid & WB.regwrite & WB.dest!=0 (loads included).
REQ-029 Register $0 never forwarded or stalled on, regardless of regwrite.
REQ-030 stall_cnt increments by 1 each cycle where hazard=1 and mem_ready=1; saturates at 16'hFFFF, never wraps.
REQ-031 Freeze cycles SHALL NOT increment stall_cnt.

Reset
REQ-032 reset_n=0 SHALL immediately clear all slot valid/regwrite/is_load bits and dest fields to 0, and stall_cnt to 0.
REQ-033 During reset: MEM_RD=0, MEM_FW=0, WB_RD=0, WB_FW=0, stall_id=0.
REQ-034 Reset asserted mid-operation discards all in-flight slots; first post-reset edge loads only ID fields.

Verification
REQ-035 ALU op dest=5 regwrite=1 at cycle 0, then bubbles -> MEM_RD=5, MEM_FW=1 after edge 2; WB_RD=5, WB_FW=1 after edge 3.
REQ-036 Load dest=8 followed by ID instr id_rs=8 -> stall_id=1 one cycle, EX bubble, stall_cnt=1; MEM_FW=0 while load in MEM; WB_FW=1 with WB_RD=8 next.
REQ-037 Load dest=0 followed by id_rs=0 -> stall_id=0, MEM_FW=0, WB_FW=0, stall_cnt unchanged.
REQ-038 Load-use hazard with ex_flush=1 same cycle -> EX bubble, stall_id=1, stall_cnt increments once.
REQ-039 mem_ready=0 for 3 cycles with ALU dest=3 in MEM -> MEM_RD=3, MEM_FW=1 held, stall_id=1 all 3 cycles, stall_cnt unchanged; advances on first ready edge.
REQ-040 Preload stall_cnt to 16'hFFFE via 2 extra hazard cycles at saturation test -> holds 16'hFFFF; reset_n pulse mid-pipeline -> all outputs 0 immediately.

Source files
------------

// File: rtl/fw_source_tracker.sv
// fw_source_tracker
// Tracks destination registers of the instructions in EX, MEM and WB so the
// datapath can forward results, and detects load-use hazards against the
// instruction sitting in ID. A count of load-use stall cycles is kept.
module fw_source_tracker (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        id_valid,
   input  logic [4:0]  id_rs,
   input  logic [4:0]  id_rt,
   input  logic        id_uses_rt,
   input  logic [4:0]  id_dest,
   input  logic        id_regwrite,
   input  logic        id_is_load,
   input  logic        ex_flush,
   input  logic        mem_ready,
   output logic [4:0]  MEM_RD,
   output logic        MEM_FW,
   output logic [4:0]  WB_RD,
   output logic        WB_FW,
   output logic        stall_id,
   output logic [15:0] stall_cnt
);

   typedef struct packed {
      logic       valid;
      logic [4:0] dest;
      logic       regwrite;
      logic       is_load;
   } slot_t;

   localparam int unsigned SLOT_EX   = 0;
   localparam int unsigned SLOT_MEM  = 1;
   localparam int unsigned SLOT_WB   = 2;
   localparam int unsigned NUM_SLOTS = 3;

   slot_t       slot_q [NUM_SLOTS];
   slot_t       slot_d [NUM_SLOTS];
   logic [15:0] stall_cnt_q;
   logic [15:0] stall_cnt_d;
   logic        hazard;
   slot_t       id_slot;

   // Load-use hazard: a load in EX writes a nonzero register that ID reads.
   always_comb begin
      hazard = slot_q[SLOT_EX].valid && slot_q[SLOT_EX].is_load &&
               slot_q[SLOT_EX].regwrite && (slot_q[SLOT_EX].dest != 5'd0) &&
               id_valid &&
               ((slot_q[SLOT_EX].dest == id_rs) ||
                (id_uses_rt && (slot_q[SLOT_EX].dest == id_rt)));
   end

   // Next-state for the slot pipeline and the saturating stall counter.
   always_comb begin
      slot_d      = slot_q;
      stall_cnt_d = stall_cnt_q;
      id_slot     = '{valid: id_valid, dest: id_dest,
                      regwrite: id_regwrite, is_load: id_is_load};
      if (mem_ready) begin
         slot_d[SLOT_WB]  = slot_q[SLOT_MEM];
         slot_d[SLOT_MEM] = slot_q[SLOT_EX];
         // Flush and load-use both squash the ID instruction into a bubble.
         slot_d[SLOT_EX]  = (ex_flush || hazard) ? '0 : id_slot;
         if (hazard && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
         end
      end
   end

   // Slot and counter registers, cleared asynchronously.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            slot_q[i] <= '0;
         end
         stall_cnt_q <= '0;
      end else begin
         slot_q      <= slot_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   // Forwarding outputs come straight from the slot registers; a load in MEM
   // has no data yet, so only WB forwards load results.
   always_comb begin
      MEM_RD    = slot_q[SLOT_MEM].dest;
      MEM_FW    = slot_q[SLOT_MEM].valid && slot_q[SLOT_MEM].regwrite &&
                  !slot_q[SLOT_MEM].is_load && (slot_q[SLOT_MEM].dest != 5'd0);
      WB_RD     = slot_q[SLOT_WB].dest;
      WB_FW     = slot_q[SLOT_WB].valid && slot_q[SLOT_WB].regwrite &&
                  (slot_q[SLOT_WB].dest != 5'd0);
      // Gated by reset so a low mem_ready cannot raise stall_id in reset.
      stall_id  = reset_n && (hazard || !mem_ready);
      stall_cnt = stall_cnt_q;
   end

endmodule

// File: tb/tb_fw_source_tracker.sv
// Directed bench for fw_source_tracker with hand-computed expectations.
module tb_fw_source_tracker;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        id_valid;
   logic [4:0]  id_rs;
   logic [4:0]  id_rt;
   logic        id_uses_rt;
   logic [4:0]  id_dest;
   logic        id_regwrite;
   logic        id_is_load;
   logic        ex_flush;
   logic        mem_ready;
   logic [4:0]  MEM_RD;
   logic        MEM_FW;
   logic [4:0]  WB_RD;
   logic        WB_FW;
   logic        stall_id;
   logic [15:0] stall_cnt;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   fw_source_tracker dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .id_valid    (id_valid),
      .id_rs       (id_rs),
      .id_rt       (id_rt),
      .id_uses_rt  (id_uses_rt),
      .id_dest     (id_dest),
      .id_regwrite (id_regwrite),
      .id_is_load  (id_is_load),
      .ex_flush    (ex_flush),
      .mem_ready   (mem_ready),
      .MEM_RD      (MEM_RD),
      .MEM_FW      (MEM_FW),
      .WB_RD       (WB_RD),
      .WB_FW       (WB_FW),
      .stall_id    (stall_id),
      .stall_cnt   (stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                           input logic urt, input logic [4:0] dest,
                           input logic rw, input logic ld);
      id_valid    = v;
      id_rs       = rs;
      id_rt       = rt;
      id_uses_rt  = urt;
      id_dest     = dest;
      id_regwrite = rw;
      id_is_load  = ld;
   endtask

   task automatic idle_id();
      drive_id(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
   endtask

   initial begin
      reset_n   = 1'b0;
      mem_ready = 1'b0;
      ex_flush  = 1'b0;
      idle_id();
      #2;
      check("rst_mem_rd",   {11'd0, MEM_RD}, 16'd0);
      check("rst_mem_fw",   {15'd0, MEM_FW}, 16'd0);
      check("rst_wb_rd",    {11'd0, WB_RD}, 16'd0);
      check("rst_wb_fw",    {15'd0, WB_FW}, 16'd0);
      check("rst_stall_id", {15'd0, stall_id}, 16'd0);
      check("rst_cnt",      stall_cnt, 16'd0);
      mem_ready = 1'b1;
      @(negedge clk);
      reset_n = 1'b1;

      // ALU op dest 5: MEM after edge 2, WB after edge 3.
      drive_id(1'b1, 5'd1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0);
      tick();
      idle_id();
      check("alu_ex_mem_rd", {11'd0, MEM_RD}, 16'd0);
      tick();
      check("alu_mem_rd", {11'd0, MEM_RD}, 16'd5);
      check("alu_mem_fw", {15'd0, MEM_FW}, 16'd1);
      tick();
      check("alu_wb_rd",  {11'd0, WB_RD}, 16'd5);
      check("alu_wb_fw",  {15'd0, WB_FW}, 16'd1);
      check("alu_mem_fw_gone", {15'd0, MEM_FW}, 16'd0);
      tick();
      check("alu_wb_fw_gone", {15'd0, WB_FW}, 16'd0);

      // Load dest 8 followed by a reader of r8.
      drive_id(1'b1, 5'd0, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1);
      tick();
      drive_id(1'b1, 5'd8, 5'd3, 1'b1, 5'd9, 1'b1, 1'b0);
      #1;
      check("lu_stall", {15'd0, stall_id}, 16'd1);
      tick();
      check("lu_cnt1",      stall_cnt, 16'd1);
      check("lu_mem_rd",    {11'd0, MEM_RD}, 16'd8);
      check("lu_mem_fw",    {15'd0, MEM_FW}, 16'd0);
      check("lu_stall_off", {15'd0, stall_id}, 16'd0);
      tick();
      idle_id();
      check("lu_wb_rd",     {11'd0, WB_RD}, 16'd8);
      check("lu_wb_fw",     {15'd0, WB_FW}, 16'd1);
      check("lu_bubble_rd", {11'd0, MEM_RD}, 16'd0);
      tick();
      check("lu_user_mem_rd", {11'd0, MEM_RD}, 16'd9);
      check("lu_user_mem_fw", {15'd0, MEM_FW}, 16'd1);

      // rt only counts when id_uses_rt; invalid ID never stalls.
      drive_id(1'b1, 5'd0, 5'd0, 1'b0, 5'd10, 1'b1, 1'b1);
      tick();
      drive_id(1'b1, 5'd1, 5'd10, 1'b0, 5'd4, 1'b1, 1'b0);
      #1;
      check("rt_unused_stall", {15'd0, stall_id}, 16'd0);
      id_uses_rt = 1'b1;
      #1;
      check("rt_used_stall", {15'd0, stall_id}, 16'd1);
      id_valid = 1'b0;
      #1;
      check("id_invalid_stall", {15'd0, stall_id}, 16'd0);
      tick();
      check("id_invalid_cnt", stall_cnt, 16'd1);
      idle_id();
      tick();
      tick();

      // Load to r0 followed by a reader of r0.
      drive_id(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1);
      tick();
      drive_id(1'b1, 5'd0, 5'd0, 1'b1, 5'd7, 1'b0, 1'b0);
      #1;
      check("r0_stall", {15'd0, stall_id}, 16'd0);
      tick();
      idle_id();
      check("r0_mem_fw", {15'd0, MEM_FW}, 16'd0);
      tick();
      check("r0_wb_fw", {15'd0, WB_FW}, 16'd0);
      check("r0_cnt",   stall_cnt, 16'd1);
      tick();
      tick();

      // Load-use with flush in the same cycle, then flush alone.
      drive_id(1'b1, 5'd0, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1);
      tick();
      drive_id(1'b1, 5'd8, 5'd0, 1'b0, 5'd12, 1'b1, 1'b0);
      ex_flush = 1'b1;
      #1;
      check("fl_lu_stall", {15'd0, stall_id}, 16'd1);
      tick();
      check("fl_lu_cnt",      stall_cnt, 16'd2);
      check("fl_only_stall",  {15'd0, stall_id}, 16'd0);
      tick();
      check("fl_mem_bubble",  {11'd0, MEM_RD}, 16'd0);
      check("fl_wb_load",     {11'd0, WB_RD}, 16'd8);
      ex_flush = 1'b0;
      idle_id();
      tick();
      check("fl_squash_rd",   {11'd0, MEM_RD}, 16'd0);
      check("fl_squash_fw",   {15'd0, MEM_FW}, 16'd0);
      check("fl_cnt_once",    stall_cnt, 16'd2);
      tick();

      // Freeze for 3 cycles with ALU dest 3 in MEM; flush is ignored.
      drive_id(1'b1, 5'd0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0);
      tick();
      idle_id();
      tick();
      check("fz_mem_rd_pre", {11'd0, MEM_RD}, 16'd3);
      mem_ready = 1'b0;
      ex_flush  = 1'b1;
      drive_id(1'b1, 5'd0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         #1;
         check("fz_stall",  {15'd0, stall_id}, 16'd1);
         tick();
         check("fz_mem_rd", {11'd0, MEM_RD}, 16'd3);
         check("fz_mem_fw", {15'd0, MEM_FW}, 16'd1);
         check("fz_cnt",    stall_cnt, 16'd2);
      end
      mem_ready = 1'b1;
      ex_flush  = 1'b0;
      idle_id();
      tick();
      check("fz_adv_wb_rd", {11'd0, WB_RD}, 16'd3);
      check("fz_adv_wb_fw", {15'd0, WB_FW}, 16'd1);
      check("fz_adv_mem_rd", {11'd0, MEM_RD}, 16'd0);

      // Hazard during a freeze counts only once ready returns.
      drive_id(1'b1, 5'd0, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1);
      tick();
      drive_id(1'b1, 5'd8, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
      mem_ready = 1'b0;
      tick();
      tick();
      check("fz_hz_cnt", stall_cnt, 16'd2);
      mem_ready = 1'b1;
      tick();
      check("fz_hz_cnt_rdy", stall_cnt, 16'd3);
      idle_id();
      tick();

      // Saturation from a preloaded 16'hFFFE.
      force dut.stall_cnt_q = 16'hFFFE;
      #1;
      release dut.stall_cnt_q;
      #1;
      check("sat_preload", stall_cnt, 16'hFFFE);
      drive_id(1'b1, 5'd0, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1);
      tick();
      drive_id(1'b1, 5'd8, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
      tick();
      check("sat_ffff", stall_cnt, 16'hFFFF);
      drive_id(1'b1, 5'd0, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1);
      tick();
      drive_id(1'b1, 5'd8, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
      #1;
      check("sat_hz_stall", {15'd0, stall_id}, 16'd1);
      tick();
      check("sat_hold", stall_cnt, 16'hFFFF);
      idle_id();
      tick();

      // Reset mid-pipeline clears everything at once and drops in-flight slots.
      drive_id(1'b1, 5'd0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
      tick();
      drive_id(1'b1, 5'd0, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0);
      tick();
      check("mr_mem_rd_pre", {11'd0, MEM_RD}, 16'd5);
      mem_ready = 1'b0;
      #1;
      reset_n = 1'b0;
      #1;
      check("mr_mem_rd",   {11'd0, MEM_RD}, 16'd0);
      check("mr_mem_fw",   {15'd0, MEM_FW}, 16'd0);
      check("mr_wb_rd",    {11'd0, WB_RD}, 16'd0);
      check("mr_wb_fw",    {15'd0, WB_FW}, 16'd0);
      check("mr_stall_id", {15'd0, stall_id}, 16'd0);
      check("mr_cnt",      stall_cnt, 16'd0);
      @(negedge clk);
      reset_n   = 1'b1;
      mem_ready = 1'b1;
      drive_id(1'b1, 5'd0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0);
      tick();
      idle_id();
      tick();
      check("mr_post_mem_rd", {11'd0, MEM_RD}, 16'd9);
      check("mr_post_wb_rd",  {11'd0, WB_RD}, 16'd0);
      check("mr_post_wb_fw",  {15'd0, WB_FW}, 16'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
